// File: rtl/cotm32_pkg.sv
// rtl/cotm32_pkg.sv - shared core constants, data-memory responder types and decode helper
package cotm32_pkg;

    localparam int XLEN       = 32;
    localparam int BYTE_WIDTH = 8;

    localparam logic [XLEN-1:0] DATA_MEM_START = 32'h1000_0000;
    localparam int              DATA_MEM_SIZE  = 4096;

    localparam int DMEM_STRB_WIDTH  = XLEN / BYTE_WIDTH;
    localparam int DMEM_MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    // Access fault: below the region, past its last byte, or not word-aligned.
    function automatic logic dmem_addr_err(
        input logic [XLEN-1:0] addr,
        input logic [XLEN-1:0] base,
        input logic [XLEN-1:0] last
    );
        return (addr < base) || (addr > last) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/cotm32_dmem_array.sv
// rtl/cotm32_dmem_array.sv - single-port word RAM with byte write enables and registered read
module cotm32_dmem_array
    import cotm32_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                       clk,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [DMEM_STRB_WIDTH-1:0] wstrb_i,
    input  logic [XLEN-1:0]            wdata_i,
    output logic [XLEN-1:0]            rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // One access per enable: byte-lane write, or read into the output register.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DMEM_STRB_WIDTH; b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[idx_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cotm32_dmem_resp.sv
// rtl/cotm32_dmem_resp.sv - LSU data-memory responder; optional COTM32_DMEM_PERF_CNT_EN adds perf counters
module cotm32_dmem_resp
    import cotm32_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR  = DATA_MEM_START,
    parameter int              SIZE_BYTES = DATA_MEM_SIZE,
    parameter int              LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [XLEN-1:0]            req_addr,
    input  logic                       req_we,
    input  logic [DMEM_STRB_WIDTH-1:0] req_wstrb,
    input  logic [XLEN-1:0]            req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [XLEN-1:0]            rsp_rdata,
    output logic                       rsp_err
`ifdef COTM32_DMEM_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]            perf_rd_cnt,
    output logic [XLEN-1:0]            perf_wr_cnt,
    output logic [XLEN-1:0]            perf_err_cnt
`endif
);

    localparam int DEPTH = SIZE_BYTES / 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DMEM_MAX_LATENCY + 1);
    localparam logic [XLEN-1:0] LAST_ADDR = BASE_ADDR + XLEN'(SIZE_BYTES - 1);

    dmem_state_t                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       we_q, we_d;
    logic [DMEM_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [XLEN-1:0]            wdata_q, wdata_d;
    logic                       err_q, err_d;
    logic                       ram_en;
    logic [XLEN-1:0]            ram_rdata;
    logic                       req_err;
    logic [IDX_W-1:0]           req_idx;

    assign req_err = dmem_addr_err(req_addr, BASE_ADDR, LAST_ADDR);
    assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);

    // Next state: capture on accept, count down the wait, fire the array on entry to RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        ram_en  = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_idx;
                    we_d    = req_we;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    if (LATENCY == 1) begin
                        state_d = DMEM_RESP;
                        ram_en  = !req_err;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DMEM_RESP;
                    ram_en  = !err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DMEM_RESP: begin
                if (rsp_ready) begin
                    state_d = DMEM_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // The _d fields carry the live request on a LATENCY==1 accept and the captured one otherwise.
    cotm32_dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en && !rst),
        .we_i    (we_d),
        .idx_i   (idx_d),
        .wstrb_i (wstrb_d),
        .wdata_i (wdata_d),
        .rdata_o (ram_rdata)
    );

    assign req_ready = (state_q == DMEM_IDLE);
    assign rsp_valid = (state_q == DMEM_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

`ifdef COTM32_DMEM_PERF_CNT_EN
    logic [XLEN-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    // Count each completed response by kind; faults count only as errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (err_q) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end else if (we_q) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end
    end

    assign perf_rd_cnt  = rd_cnt_q;
    assign perf_wr_cnt  = wr_cnt_q;
    assign perf_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cotm32_dmem_resp.sv
// tb/tb_cotm32_dmem_resp.sv - self-checking bench for two responders (LATENCY 1 and 4)
module tb_cotm32_dmem_resp;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          SIZE = 4096;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_we    [2];
    logic [3:0]  req_wstrb [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef COTM32_DMEM_PERF_CNT_EN
    logic [31:0] perf_rd  [2];
    logic [31:0] perf_wr  [2];
    logic [31:0] perf_err [2];
`endif

    int passed = 0;
    int total  = 0;

    logic [31:0] mem_m [int];
    int          n_rd [2];
    int          n_wr [2];
    int          n_er [2];

    cotm32_dmem_resp #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_we(req_we[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef COTM32_DMEM_PERF_CNT_EN
        , .perf_rd_cnt(perf_rd[0]), .perf_wr_cnt(perf_wr[0]), .perf_err_cnt(perf_err[0])
`endif
    );

    cotm32_dmem_resp #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_we(req_we[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef COTM32_DMEM_PERF_CNT_EN
        , .perf_rd_cnt(perf_rd[1]), .perf_wr_cnt(perf_wr[1]), .perf_err_cnt(perf_err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference model: region decode by address arithmetic, word store keyed by (dut, word).
    task automatic model(input int d, input logic [31:0] a, input logic we, input logic [3:0] s,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_er);
        int key;
        logic [31:0] w;
        e_er = (a < BASE) || (a > BASE + SIZE - 1) || (a % 4 != 0);
        e_rd = 32'h0;
        key  = d * 100000 + int'((a - BASE) / 4);
        if (e_er) begin
            n_er[d]++;
        end else if (we) begin
            n_wr[d]++;
            w = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    w = (w & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
                end
            end
            mem_m[key] = w;
        end else begin
            n_rd[d]++;
            e_rd = mem_m.exists(key) ? mem_m[key] : 32'h0;
        end
    endtask

    // One full transaction: accept, measured latency, optional back-pressure, handshake.
    task automatic txn(input int d, input logic [31:0] a, input logic we, input logic [3:0] s,
                       input logic [31:0] wd, input int hold, input bit early,
                       input logic [31:0] e_rd, input logic e_er);
        int b;
        int lat;
        req_addr[d]  = a;
        req_we[d]    = we;
        req_wstrb[d] = s;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        b = 0;
        while (!req_ready[d] && b < 50) begin
            @(posedge clk); #1; b++;
        end
        chk("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        if (early) rsp_ready[d] = 1'b1;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            chk("req_ready_in_wait", 32'(req_ready[d]), 32'd0);
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(lat_of(d)));
        chk("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
        chk("rsp_rdata", rsp_rdata[d], e_rd);
        chk("rsp_err", 32'(rsp_err[d]), 32'(e_er));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
                chk("hold_rsp_rdata", rsp_rdata[d], e_rd);
                chk("hold_rsp_err", 32'(rsp_err[d]), 32'(e_er));
                chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        chk("post_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
        chk("post_hs_rsp_rdata", rsp_rdata[d], 32'h0);
        chk("post_hs_rsp_err", 32'(rsp_err[d]), 32'd0);
    endtask

    task automatic mtxn(input int d, input logic [31:0] a, input logic we, input logic [3:0] s,
                        input logic [31:0] wd, input int hold, input bit early);
        logic [31:0] e_rd;
        logic        e_er;
        model(d, a, we, s, wd, e_rd, e_er);
        txn(d, a, we, s, wd, hold, early, e_rd, e_er);
    endtask

    // Start a write and stop it with reset after 'cycles' cycles; no handshake happens.
    task automatic reset_mid(input int d, input logic [31:0] a, input logic [31:0] wd, input int cycles);
        req_addr[d]  = a;
        req_we[d]    = 1'b1;
        req_wstrb[d] = 4'hF;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        n_rd[d] = 0; n_wr[d] = 0; n_er[d] = 0;
        chk("rst_mid_req_ready", 32'(req_ready[d]), 32'd1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("rst_mid_rsp_rdata", rsp_rdata[d], 32'h0);
        chk("rst_mid_rsp_err", 32'(rsp_err[d]), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] e_rd;
        logic        e_er;
        tbl[0]  = '{32'h1000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{32'h1000_0010, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{32'h1000_0014, 1'b1, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
        tbl[3]  = '{32'h1000_0014, 1'b1, 4'h2, 32'h0000_AA00, 32'h0,         1'b0};
        tbl[4]  = '{32'h1000_0014, 1'b0, 4'h0, 32'h0,         32'h1122_AA44, 1'b0};
        tbl[5]  = '{32'h1000_1000, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[6]  = '{32'h0FFF_FFFC, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[7]  = '{32'h1000_0002, 1'b0, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[8]  = '{32'h1000_0FFC, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0};
        tbl[9]  = '{32'h1000_0FFC, 1'b0, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[10] = '{32'h1000_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 32'h0,         1'b0};
        tbl[11] = '{32'h1000_1000, 1'b1, 4'hF, 32'h5A5A_5A5A, 32'h0,         1'b1};
        tbl[12] = '{32'h1000_0000, 1'b0, 4'h0, 32'h0,         32'hA5A5_A5A5, 1'b0};
        tbl[13] = '{32'h1000_0018, 1'b1, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
        tbl[14] = '{32'h1000_0018, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[15] = '{32'h1000_0018, 1'b0, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
        tbl[16] = '{32'h1000_0012, 1'b1, 4'hF, 32'h0,         32'h0,         1'b1};
        tbl[17] = '{32'h1000_0010, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; req_we[d] = 1'b0;
            req_wstrb[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
            n_rd[d] = 0; n_wr[d] = 0; n_er[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[d], 32'h0);
            chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
        end

        // Directed vectors, expectations fixed in the table.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 18; i++) begin
                model(d, tbl[i].addr, tbl[i].we, tbl[i].strb, tbl[i].wdata, e_rd, e_er);
                txn(d, tbl[i].addr, tbl[i].we, tbl[i].strb, tbl[i].wdata, 0, 1'b0,
                    tbl[i].exp_rd, tbl[i].exp_er);
            end
        end

        // Back-pressure on the LATENCY=4 responder: three stalled cycles.
        txn(1, 32'h1000_0010, 1'b0, 4'h0, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);
        n_rd[1]++;

        // Reset while waiting drops the write; reset while responding keeps it.
        mtxn(1, 32'h1000_0020, 1'b1, 4'hF, 32'h0, 0, 1'b0);
        reset_mid(1, 32'h1000_0020, 32'h0000_0055, 1);
        txn(1, 32'h1000_0020, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        n_rd[1]++;
        mtxn(1, 32'h1000_0024, 1'b1, 4'hF, 32'h0, 0, 1'b0);
        reset_mid(1, 32'h1000_0024, 32'h0000_0077, 3);
        txn(1, 32'h1000_0024, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0000_0077, 1'b0);
        n_rd[1]++;
        mem_m[100000 + 9] = 32'h0000_0077;

        // Randomized traffic over a preloaded word pool plus boundary addresses.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                mtxn(d, BASE + 32'(4 * k), 1'b1, 4'hF, $urandom, 0, 1'b0);
            end
            for (int n = 0; n < 80; n++) begin
                logic [31:0] a;
                int r;
                r = $urandom_range(0, 9);
                case (r)
                    6:       a = BASE + SIZE;
                    7:       a = BASE - 4;
                    8:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                    9:       a = BASE + SIZE - 4;
                    default: a = BASE + 32'(4 * $urandom_range(0, 15));
                endcase
                mtxn(d, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

`ifdef COTM32_DMEM_PERF_CNT_EN
        for (int d = 0; d < 2; d++) begin
            chk("perf_rd_cnt", perf_rd[d], 32'(n_rd[d]));
            chk("perf_wr_cnt", perf_wr[d], 32'(n_wr[d]));
            chk("perf_err_cnt", perf_err[d], 32'(n_er[d]));
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
